// File: rtl/uart_cmd_rx_if.sv
// Command handshake bundle between the UART command receiver and the FSM/ALU path.
interface uart_cmd_rx_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_opcode;
  logic [3:0] cmd_a;
  logic [3:0] cmd_b;

  modport master (output cmd_valid, cmd_opcode, cmd_a, cmd_b, input cmd_ready);
  modport slave  (input cmd_valid, cmd_opcode, cmd_a, cmd_b, output cmd_ready);
endinterface

// File: rtl/uart_cmd_rx.sv
// UART (8N1, or 8E1 with UART_CMD_RX_PARITY_EN) receiver decoding two-byte ALU command frames.
// Optional feature macro: UART_CMD_RX_PARITY_EN.
module uart_cmd_rx #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TIMEOUT_BITS = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx,
  uart_cmd_rx_if.master    cmd,
  output logic             frame_err,
  output logic             overrun
);

  localparam int unsigned CNT_W     = $clog2(CLKS_PER_BIT);
  localparam int unsigned HALF_M1   = CLKS_PER_BIT / 2 - 1;
  localparam int unsigned TO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TO_W      = $clog2(TO_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_CMD_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_WAIT_HIGH
  } rx_state_t;

  typedef enum logic {F_HDR, F_OPND} frm_state_t;

  logic             sync1, rx_s;
  rx_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  frm_state_t       frm;
  logic [2:0]       op_hdr;
  logic [TO_W-1:0]  to_cnt;
  logic             valid_q;
  logic [2:0]       opcode_q;
  logic [3:0]       a_q, b_q;
`ifdef UART_CMD_RX_PARITY_EN
  logic             par_err;
`endif

  logic bit_tick_c, byte_done_c, bit_err_c, hdr_ok_c, frame_done_c, hdr_err_c;

  // Byte-level strobes, all taken on the sampling cycle so the registered pulses land one cycle later
  assign bit_tick_c = (cnt == CNT_W'(CLKS_PER_BIT - 1));
`ifdef UART_CMD_RX_PARITY_EN
  assign byte_done_c = (state == S_STOP) && bit_tick_c && rx_s && !par_err;
  assign bit_err_c   = ((state == S_STOP) && bit_tick_c && !rx_s) ||
                       ((state == S_PARITY) && bit_tick_c && ((^shreg) ^ rx_s));
`else
  assign byte_done_c = (state == S_STOP) && bit_tick_c && rx_s;
  assign bit_err_c   = (state == S_STOP) && bit_tick_c && !rx_s;
`endif
  assign hdr_ok_c     = (shreg[7:3] == 5'b10101);
  assign frame_done_c = (frm == F_OPND) && byte_done_c;
  assign hdr_err_c    = (frm == F_HDR) && byte_done_c && !hdr_ok_c;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      frm       <= F_HDR;
      op_hdr    <= '0;
      to_cnt    <= '0;
      valid_q   <= 1'b0;
      opcode_q  <= '0;
      a_q       <= '0;
      b_q       <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_CMD_RX_PARITY_EN
      par_err   <= 1'b0;
`endif
    end else begin
      sync1     <= rx;
      rx_s      <= sync1;
      frame_err <= bit_err_c | hdr_err_c;
      overrun   <= 1'b0;

      // Bit-level receiver
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= '0;
          end
        end
        S_START: begin
          if (cnt == CNT_W'(HALF_M1)) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? S_IDLE : S_DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DATA: begin
          if (bit_tick_c) begin
            cnt     <= '0;
            shreg   <= {rx_s, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
`ifdef UART_CMD_RX_PARITY_EN
              state <= S_PARITY;
`else
              state <= S_STOP;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`ifdef UART_CMD_RX_PARITY_EN
        S_PARITY: begin
          if (bit_tick_c) begin
            cnt     <= '0;
            par_err <= (^shreg) ^ rx_s;
            state   <= S_STOP;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
`endif
        S_STOP: begin
          if (bit_tick_c) begin
            cnt   <= '0;
            state <= rx_s ? S_IDLE : S_WAIT_HIGH;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_WAIT_HIGH: begin
          if (rx_s) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase

      // Frame layer: header latches the opcode, operand byte or timeout/error returns to HDR
      case (frm)
        F_HDR: begin
          if (byte_done_c && hdr_ok_c) begin
            op_hdr <= shreg[2:0];
            frm    <= F_OPND;
            to_cnt <= '0;
          end
        end
        F_OPND: begin
          if (byte_done_c || bit_err_c || (to_cnt == TO_W'(TO_CYCLES - 1))) begin
            frm <= F_HDR;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
          end
        end
        default: frm <= F_HDR;
      endcase

      // Output holding register; a transfer on the completion cycle frees the slot for the new frame
      if (valid_q && cmd.cmd_ready) valid_q <= 1'b0;
      if (frame_done_c) begin
        if (!valid_q || cmd.cmd_ready) begin
          valid_q  <= 1'b1;
          opcode_q <= op_hdr;
          a_q      <= shreg[7:4];
          b_q      <= shreg[3:0];
        end else begin
          overrun <= 1'b1;
        end
      end
    end
  end

  assign cmd.cmd_valid  = valid_q;
  assign cmd.cmd_opcode = opcode_q;
  assign cmd.cmd_a      = a_q;
  assign cmd.cmd_b      = b_q;

endmodule

// File: doc/uart_cmd_rx.md
# uart_cmd_rx

Serial command receiver for the Jsilicon core: the receive-side counterpart of the core's UART transmitter. It deserialises 8N1 UART bytes from an external host and checks a two-byte command frame. It then presents the decoded opcode and 4-bit operands to the FSM/ALU path through a valid/ready handshake. This lets the ALU be driven over one serial pin instead of the parallel `ui_in`/`uio_in` pins.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal range 4–65535.
- `TIMEOUT_BITS`, default 20: bit periods allowed between header byte and operand byte before the frame is abandoned.

Ports:
- `clock`  in  1: single clock; all logic on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `rx`  in  1: asynchronous serial input; idle high.
- `cmd_ready`  in  1: consumer accepts the command.
- `cmd_valid`  out  1: a decoded command is held on the `cmd_*` outputs.
- `cmd_opcode`  out  3: ALU opcode.
- `cmd_a`  out  4: operand A.
- `cmd_b`  out  4: operand B.
- `frame_err`  out  1: one-cycle pulse on a bad stop bit, bad parity, or bad header.
- `overrun`  out  1: one-cycle pulse when a completed frame is dropped because `cmd_valid` is still pending.

## Operation
- `rx` passes through a 2-FF synchroniser; both flops reset to 1.
- Bit-level receiver states: IDLE → START → DATA → (PARITY) → STOP → IDLE, plus WAIT_HIGH.
- IDLE: a synchronised 0 enters START and clears the divider.
- START:
  - At `CLKS_PER_BIT/2` (integer divide), resample `rx`.
  - 1 means a glitch: return to IDLE with no error.
  - 0 means a valid start: enter DATA.
- DATA: 8 samples, one every `CLKS_PER_BIT` cycles, shifted in LSB first.
- STOP:
  - Sample one bit period after the last data or parity bit.
  - 1: the byte is complete and an internal `byte_done` strobes for one cycle.
  - 0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
- WAIT_HIGH: stay until synchronised `rx` = 1, then go to IDLE (handles break conditions).
- Frame layer states: HDR and OPND.
  - HDR, on `byte_done`:
    - If byte[7:3] = 5'b10101, latch opcode = byte[2:0] and go to OPND.
    - Otherwise pulse `frame_err` and stay in HDR.
  - OPND, on `byte_done`: A = byte[7:4], B = byte[3:0]; the frame is complete; return to HDR.
  - OPND timeout:
    - A counter starts at the header's `byte_done` and counts `TIMEOUT_BITS × CLKS_PER_BIT` cycles.
    - On expiry, return to HDR silently with no pulse.
    - A bit-level error while in OPND also returns to HDR.
- Frame complete:
  - If `cmd_valid` = 0, load `cmd_*` and set `cmd_valid`.
  - If `cmd_valid` = 1, pulse `overrun`, drop the new frame, and leave held outputs unchanged.
- Handshake:
  - The transfer occurs on a cycle with `cmd_valid && cmd_ready`.
  - `cmd_valid` clears on the next edge.
  - `cmd_*` hold stable while `cmd_valid` = 1 and keep their last value after clearing.
- Frame completion on the same cycle as a transfer: the transfer wins the old data, the new frame loads, `cmd_valid` stays 1, and there is no overrun.

## Timing
- Reset values: `cmd_valid`=0, `cmd_opcode`=0, `cmd_a`=0, `cmd_b`=0, `frame_err`=0, `overrun`=0. Receiver goes to IDLE and the frame layer to HDR.
- Reset asserted mid-byte or mid-frame aborts everything; no pulse is generated.
- Synchroniser latency is 2 cycles.
- Data bit n is sampled `(n+1)×CLKS_PER_BIT + CLKS_PER_BIT/2` cycles after the start edge is seen at the synchroniser output.
- `cmd_valid` rises exactly 1 cycle after the operand byte's stop-bit sample.
- `frame_err` and `overrun` are registered and asserted exactly 1 cycle after the causing sample.
- Throughput: back-to-back bytes with a single stop bit are accepted; the receiver re-arms for a start edge on the cycle after the stop sample.

## Configuration
- `UART_CMD_RX_PARITY_EN` defined:
  - Frame format is 8E1; the PARITY state samples one extra bit after D7.
  - If the XOR of the 8 data bits and the parity bit ≠ 0, pulse `frame_err`, discard the byte, and still check the stop bit before returning to IDLE.
  - All stop and data timing shifts by one bit period.
- Undefined: 8N1; the PARITY state and its logic are absent.

## Test plan
- CLKS_PER_BIT=16: send 0xA9 then 0x35 with `cmd_ready`=1 → `cmd_valid` pulses one cycle with opcode=1, A=3, B=5, no error pulses.
- Send 0x55 as a header → `frame_err` one pulse, `cmd_valid` stays 0. Then send 0xAE, 0xF0 → opcode=6, A=15, B=0.
- With `cmd_ready`=0, send frame (0xA9, 0x12) then frame (0xAA, 0x34):
  - `cmd_valid` holds opcode=1, A=1, B=2, and `overrun` pulses once.
  - Then raise `cmd_ready` → `cmd_valid` drops next cycle.
- Send 0xAB, then idle 25 bit periods, then 0x77 → no command is produced. 0x77 is then treated as a header and rejected with `frame_err`.
- Drive `rx` low for 4 cycles (glitch) → no byte, no error. Send byte 0xA9 with its stop bit forced to 0 → `frame_err`, receiver waits for `rx` high.
- Assert `reset` in the middle of the operand byte → all outputs 0. The next clean frame (0xAF, 0x9C) decodes as opcode=7, A=9, B=12.
